wb_stage: RTL and testbench
===========================

WB_STAGE -- requirements
Module: wb_stage

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath width.
REQ-002 SHALL have parameter LQ_DEPTH, default 2, load-result queue entries; legal values 2, 4 or 8.
REQ-003 SHALL have port clk  input  1  clock, rising-edge active.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port alu_valid_i  input  1  ALU result valid; this channel has no backpressure.
REQ-006 SHALL have port alu_rd_idx_i  input  5  ALU destination register.
REQ-007 SHALL have port alu_wdata_i  input  XLEN  ALU result.
REQ-008 SHALL have port lsu_valid_i  input  1  load data valid.
REQ-009 SHALL have port lsu_ready_o  output  1  load data accepted when high together with lsu_valid_i.
REQ-010 SHALL have port lsu_rd_idx_i  input  5  load destination register.
REQ-011 SHALL have port lsu_rdata_i  input  XLEN  raw aligned bus word.
REQ-012 SHALL have port lsu_size_i  input  2  00 byte, 01 half, 10 word, 11 treated as word.
REQ-013 SHALL have port lsu_unsigned_i  input  1  1 means zero-extend, 0 means sign-extend.
REQ-014 SHALL have port lsu_addr_lo_i  input  2  byte offset within the word.
REQ-015 SHALL have port rd_en_o  output  1  register-file write enable.
REQ-016 SHALL have port rd_idx_o  output  5  register-file write index.
REQ-017 SHALL have port rd_wdata_o  output  XLEN  register-file write data.
REQ-018 SHALL have port pend_o  output  32  bitmask of destinations held in the load queue; goes to decode for hazard stalls.

Function
REQ-019 SHALL format load data on acceptance, as follows:
- byte: lsu_rdata_i[8*addr_lo +: 8].
- half: lsu_rdata_i[16*addr_lo[1] +: 16]; addr_lo[0] is ignored.
- word: lsu_rdata_i unchanged.
- extension to XLEN: zero if lsu_unsigned_i=1, otherwise sign.
REQ-020 SHALL store accepted loads with rd!=0 in a FIFO load queue of LQ_DEPTH entries (index plus formatted data); the queue keeps an occupancy count from 0 to LQ_DEPTH.
REQ-021 SHALL accept and discard loads with rd=0, with no queue entry and no write.
REQ-022 SHALL drive lsu_ready_o = (count != LQ_DEPTH), combinational from the count only and independent of this cycle's pop.
REQ-023 SHALL select one write source each cycle, in this priority:
- ALU, if alu_valid_i=1 and alu_rd_idx_i!=0.
- Otherwise the queue head, if count>0; the head is popped.
- Otherwise no write.
REQ-024 SHALL NOT write for an ALU result with rd=0; that cycle is available to the queue.
REQ-025 SHALL register the selected write into rd_en_o, rd_idx_o and rd_wdata_o at the next rising edge, giving 1-cycle ALU latency.
REQ-026 SHALL keep rd_idx_o and rd_wdata_o at their previous values while rd_en_o=0.
REQ-027 SHALL give a load accepted at edge N into an empty queue rd_en_o=1 after edge N+1 if no ALU write competes; minimum load latency is 2 cycles.
REQ-028 SHALL handle push and pop in the same cycle: count unchanged, FIFO order preserved.
REQ-029 SHALL wrap the read and write pointers modulo LQ_DEPTH.
REQ-030 SHALL NOT drop or reorder queued loads under continuous ALU writes; loads wait and lsu_ready_o falls when the queue is full.
REQ-031 SHALL drive pend_o as the OR of one-hot(rd) over valid queue entries, combinational from queue state; pend_o[0] is always 0.
REQ-032 SHALL clear a popped entry's pend_o bit in the same cycle its write appears on rd_en_o.
REQ-033 SHALL NOT fault when the same rd is queued twice; its pend_o bit stays set until both entries have been popped.

Reset
REQ-034 SHALL, while rst_n=0 (asynchronous):
- set rd_en_o=0, rd_idx_o=0, rd_wdata_o=0;
- set count=0 and both pointers to 0;
- which gives pend_o=0 and lsu_ready_o=1.
REQ-035 SHALL discard queued loads if reset asserts mid-operation, with no write emitted after release.
REQ-036 SHALL accept a new load in the first cycle after reset release.

Verification
REQ-037 SHALL check ALU path: alu_valid=1, rd=5, data=0x1234_5678 -> next cycle rd_en_o=1, rd_idx_o=5, rd_wdata_o=0x1234_5678.
REQ-038 SHALL check load formatting with lsu_rdata=0x80FF_7F01:
- byte, addr_lo=2, signed -> 0xFFFF_FFFF.
- byte, addr_lo=3, unsigned -> 0x0000_0080.
- half, addr_lo=2, signed -> 0xFFFF_80FF.
REQ-039 SHALL check priority: ALU rd=3 and a queued load rd=7 in the same cycle -> write x3 first, then x7 the next cycle; pend_o[7] stays 1 until the x7 write.
REQ-040 SHALL check backpressure: LQ_DEPTH=2, ALU valid every cycle, 3 loads offered -> lsu_ready_o=0 after 2 accepted; all 3 loads are written in order once the ALU idles.
REQ-041 SHALL check rd=0 handling: ALU rd=0 and load rd=0 -> no rd_en_o pulse, pend_o=0, count=0.
REQ-042 SHALL check reset mid-operation: 2 loads queued, rst_n pulsed low -> pend_o=0, lsu_ready_o=1, and no rd_en_o after release.

Source files
------------

// File: rtl/wb_stage.sv
// Writeback stage: merges the unstalled ALU result stream with a small FIFO of
// formatted load results into the single register-file write port.
module wb_stage #(
    parameter int XLEN     = 32,
    parameter int LQ_DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            alu_valid_i,
    input  logic [4:0]      alu_rd_idx_i,
    input  logic [XLEN-1:0] alu_wdata_i,
    input  logic            lsu_valid_i,
    output logic            lsu_ready_o,
    input  logic [4:0]      lsu_rd_idx_i,
    input  logic [XLEN-1:0] lsu_rdata_i,
    input  logic [1:0]      lsu_size_i,
    input  logic            lsu_unsigned_i,
    input  logic [1:0]      lsu_addr_lo_i,
    output logic            rd_en_o,
    output logic [4:0]      rd_idx_o,
    output logic [XLEN-1:0] rd_wdata_o,
    output logic [31:0]     pend_o
);

    localparam int PTR_W = $clog2(LQ_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL = CNT_W'(LQ_DEPTH);

    logic [4:0]      q_idx  [LQ_DEPTH];
    logic [XLEN-1:0] q_data [LQ_DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [CNT_W-1:0] count;

    logic [7:0]      ld_byte;
    logic [15:0]     ld_half;
    logic [XLEN-1:0] load_fmt;
    logic            push, pop, alu_sel;

    assign ld_byte = lsu_rdata_i[{lsu_addr_lo_i, 3'b000} +: 8];
    assign ld_half = lsu_rdata_i[{lsu_addr_lo_i[1], 4'b0000} +: 16];

    always_comb begin
        load_fmt = lsu_rdata_i;
        case (lsu_size_i)
            2'b00:   load_fmt = {{(XLEN-8){~lsu_unsigned_i & ld_byte[7]}}, ld_byte};
            2'b01:   load_fmt = {{(XLEN-16){~lsu_unsigned_i & ld_half[15]}}, ld_half};
            default: load_fmt = lsu_rdata_i;
        endcase
    end

    // Loads to x0 are still handshaken so the LSU never stalls on them.
    assign lsu_ready_o = (count != FULL);
    assign push        = lsu_valid_i & lsu_ready_o & (lsu_rd_idx_i != 5'd0);
    assign alu_sel     = alu_valid_i & (alu_rd_idx_i != 5'd0);
    assign pop         = ~alu_sel & (count != '0);

    // An entry is live when its distance from the read pointer is below count.
    always_comb begin
        logic [PTR_W-1:0] offs;
        pend_o = '0;
        for (int i = 0; i < LQ_DEPTH; i++) begin
            offs = PTR_W'(i) - rd_ptr;
            if (CNT_W'(offs) < count)
                pend_o[q_idx[i]] = 1'b1;
        end
        pend_o[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (push) begin
            q_idx[wr_ptr]  <= lsu_rd_idx_i;
            q_data[wr_ptr] <= load_fmt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            rd_en_o    <= 1'b0;
            rd_idx_o   <= '0;
            rd_wdata_o <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)
                count <= count + 1'b1;
            else if (pop && !push)
                count <= count - 1'b1;

            rd_en_o <= alu_sel | pop;
            if (alu_sel) begin
                rd_idx_o   <= alu_rd_idx_i;
                rd_wdata_o <= alu_wdata_i;
            end else if (pop) begin
                rd_idx_o   <= q_idx[rd_ptr];
                rd_wdata_o <= q_data[rd_ptr];
            end
        end
    end

endmodule

// File: tb/tb_wb_stage.sv
// Directed bench for wb_stage: expected writes go into a scoreboard queue and a
// negedge monitor pops and compares every register-file write it observes.
module tb_wb_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        alu_valid_i;
    logic [4:0]  alu_rd_idx_i;
    logic [31:0] alu_wdata_i;
    logic        lsu_valid_i;
    logic        lsu_ready_o;
    logic [4:0]  lsu_rd_idx_i;
    logic [31:0] lsu_rdata_i;
    logic [1:0]  lsu_size_i;
    logic        lsu_unsigned_i;
    logic [1:0]  lsu_addr_lo_i;
    logic        rd_en_o;
    logic [4:0]  rd_idx_o;
    logic [31:0] rd_wdata_o;
    logic [31:0] pend_o;

    typedef struct packed {
        logic [4:0]  idx;
        logic [31:0] data;
    } wr_t;

    typedef struct packed {
        logic [4:0]  rd;
        logic [1:0]  size;
        logic        uns;
        logic [1:0]  addr;
        logic [31:0] exp;
    } fmt_t;

    wr_t         sb[$];
    wr_t         exp_w;
    fmt_t        fmt_vecs [9];
    int          total = 0;
    int          bad   = 0;
    logic [4:0]  last_idx  = '0;
    logic [31:0] last_data = '0;

    wb_stage #(.XLEN(32), .LQ_DEPTH(2)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .alu_valid_i    (alu_valid_i),
        .alu_rd_idx_i   (alu_rd_idx_i),
        .alu_wdata_i    (alu_wdata_i),
        .lsu_valid_i    (lsu_valid_i),
        .lsu_ready_o    (lsu_ready_o),
        .lsu_rd_idx_i   (lsu_rd_idx_i),
        .lsu_rdata_i    (lsu_rdata_i),
        .lsu_size_i     (lsu_size_i),
        .lsu_unsigned_i (lsu_unsigned_i),
        .lsu_addr_lo_i  (lsu_addr_lo_i),
        .rd_en_o        (rd_en_o),
        .rd_idx_o       (rd_idx_o),
        .rd_wdata_o     (rd_wdata_o),
        .pend_o         (pend_o)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic av, input logic [4:0] ard, input logic [31:0] ad,
                                 input logic lv, input logic [4:0] lrd, input logic [31:0] ld,
                                 input logic [1:0] sz, input logic uns, input logic [1:0] alo);
        alu_valid_i    = av;
        alu_rd_idx_i   = ard;
        alu_wdata_i    = ad;
        lsu_valid_i    = lv;
        lsu_rd_idx_i   = lrd;
        lsu_rdata_i    = ld;
        lsu_size_i     = sz;
        lsu_unsigned_i = uns;
        lsu_addr_lo_i  = alo;
    endtask

    task automatic idle();
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 2'd0, 1'b0, 2'd0);
    endtask

    task automatic expectWrite(input logic [4:0] idx, input logic [31:0] data);
        sb.push_back('{idx: idx, data: data});
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 20 && sb.size() != 0; i++)
            tick();
        checkOutput(name, sb.size(), 0);
    endtask

    // Every write must match the head of the scoreboard; idle cycles must hold the bus.
    always @(negedge clk) begin
        if (!rst_n) begin
            last_idx  = '0;
            last_data = '0;
        end else if (rd_en_o) begin
            total++;
            if (sb.size() == 0) begin
                bad++;
                $display("[TB] FAIL unexpected write: got x%0d=0x%08h expected no write",
                         rd_idx_o, rd_wdata_o);
            end else begin
                exp_w = sb.pop_front();
                if (rd_idx_o !== exp_w.idx || rd_wdata_o !== exp_w.data) begin
                    bad++;
                    $display("[TB] FAIL write: got x%0d=0x%08h expected x%0d=0x%08h",
                             rd_idx_o, rd_wdata_o, exp_w.idx, exp_w.data);
                end
            end
            last_idx  = rd_idx_o;
            last_data = rd_wdata_o;
        end else begin
            total++;
            if (rd_idx_o !== last_idx || rd_wdata_o !== last_data) begin
                bad++;
                $display("[TB] FAIL idle hold: got x%0d=0x%08h expected x%0d=0x%08h",
                         rd_idx_o, rd_wdata_o, last_idx, last_data);
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        fmt_vecs = '{
            '{5'd11, 2'd0, 1'b1, 2'd3, 32'h0000_0080},
            '{5'd12, 2'd1, 1'b0, 2'd2, 32'hFFFF_80FF},
            '{5'd13, 2'd2, 1'b0, 2'd0, 32'h80FF_7F01},
            '{5'd14, 2'd1, 1'b1, 2'd0, 32'h0000_7F01},
            '{5'd15, 2'd0, 1'b0, 2'd1, 32'h0000_007F},
            '{5'd16, 2'd3, 1'b1, 2'd1, 32'h80FF_7F01},
            '{5'd17, 2'd1, 1'b0, 2'd3, 32'hFFFF_80FF},
            '{5'd18, 2'd0, 1'b0, 2'd3, 32'hFFFF_FF80},
            '{5'd19, 2'd1, 1'b0, 2'd0, 32'h0000_7F01}
        };

        rst_n = 1'b0;
        idle();
        #2;
        checkOutput("reset rd_en", 32'(rd_en_o), 32'd0);
        checkOutput("reset rd_idx", 32'(rd_idx_o), 32'd0);
        checkOutput("reset rd_wdata", rd_wdata_o, 32'd0);
        checkOutput("reset pend", pend_o, 32'd0);
        checkOutput("reset ready", 32'(lsu_ready_o), 32'd1);
        repeat (2) tick();
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // ALU path, one-cycle latency
        applyStimulus(1'b1, 5'd5, 32'h1234_5678, 1'b0, 5'd0, 32'h0, 2'd0, 1'b0, 2'd0);
        expectWrite(5'd5, 32'h1234_5678);
        tick();
        idle();
        checkOutput("alu rd_en", 32'(rd_en_o), 32'd1);
        checkOutput("alu rd_idx", 32'(rd_idx_o), 32'd5);
        checkOutput("alu rd_wdata", rd_wdata_o, 32'h1234_5678);
        tick();

        // First load: two-cycle latency and pend bit lifetime
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd10, 32'h80FF_7F01, 2'd0, 1'b0, 2'd2);
        expectWrite(5'd10, 32'hFFFF_FFFF);
        tick();
        idle();
        checkOutput("load lat1 rd_en", 32'(rd_en_o), 32'd0);
        checkOutput("load pend x10", pend_o, 32'h0000_0400);
        tick();
        checkOutput("load lat2 rd_en", 32'(rd_en_o), 32'd1);
        checkOutput("load lat2 rd_idx", 32'(rd_idx_o), 32'd10);
        checkOutput("load pend cleared", pend_o, 32'd0);

        // Load formatting table, back to back
        foreach (fmt_vecs[i]) begin
            applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, fmt_vecs[i].rd, 32'h80FF_7F01,
                          fmt_vecs[i].size, fmt_vecs[i].uns, fmt_vecs[i].addr);
            expectWrite(fmt_vecs[i].rd, fmt_vecs[i].exp);
            tick();
        end
        idle();
        drain("format drained");

        // Priority: ALU x3 beats queued x7
        expectWrite(5'd3, 32'h0000_0033);
        expectWrite(5'd7, 32'h0000_0077);
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 32'h0000_0077, 2'd2, 1'b0, 2'd0);
        tick();
        applyStimulus(1'b1, 5'd3, 32'h0000_0033, 1'b0, 5'd0, 32'h0, 2'd0, 1'b0, 2'd0);
        checkOutput("prio pend x7 queued", pend_o, 32'h0000_0080);
        tick();
        idle();
        checkOutput("prio first idx", 32'(rd_idx_o), 32'd3);
        checkOutput("prio pend x7 held", pend_o, 32'h0000_0080);
        tick();
        checkOutput("prio second idx", 32'(rd_idx_o), 32'd7);
        checkOutput("prio pend x7 cleared", pend_o, 32'd0);
        drain("prio drained");

        // Backpressure under continuous ALU writes
        for (int i = 0; i < 4; i++)
            expectWrite(5'd4, 32'h0000_00A0 + 32'(i));
        expectWrite(5'd20, 32'h0000_0014);
        expectWrite(5'd21, 32'h0000_0015);
        expectWrite(5'd22, 32'h0000_0016);
        applyStimulus(1'b1, 5'd4, 32'h0000_00A0, 1'b1, 5'd20, 32'h0000_0014, 2'd2, 1'b0, 2'd0);
        tick();
        applyStimulus(1'b1, 5'd4, 32'h0000_00A1, 1'b1, 5'd21, 32'h0000_0015, 2'd2, 1'b0, 2'd0);
        tick();
        applyStimulus(1'b1, 5'd4, 32'h0000_00A2, 1'b1, 5'd22, 32'h0000_0016, 2'd2, 1'b0, 2'd0);
        checkOutput("bp ready full", 32'(lsu_ready_o), 32'd0);
        checkOutput("bp pend full", pend_o, 32'h0030_0000);
        tick();
        applyStimulus(1'b1, 5'd4, 32'h0000_00A3, 1'b1, 5'd22, 32'h0000_0016, 2'd2, 1'b0, 2'd0);
        checkOutput("bp ready held", 32'(lsu_ready_o), 32'd0);
        tick();
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd22, 32'h0000_0016, 2'd2, 1'b0, 2'd0);
        checkOutput("bp ready alu idle", 32'(lsu_ready_o), 32'd0);
        tick();
        checkOutput("bp ready reopen", 32'(lsu_ready_o), 32'd1);
        checkOutput("bp pend after pop", pend_o, 32'h0020_0000);
        tick();
        idle();
        drain("bp drained");

        // rd=0 on both channels, then ALU x0 leaves the slot to the queue
        applyStimulus(1'b1, 5'd0, 32'h0000_DEAD, 1'b1, 5'd0, 32'h0000_BEEF, 2'd2, 1'b0, 2'd0);
        tick();
        idle();
        checkOutput("x0 rd_en", 32'(rd_en_o), 32'd0);
        checkOutput("x0 pend", pend_o, 32'd0);
        checkOutput("x0 ready", 32'(lsu_ready_o), 32'd1);
        expectWrite(5'd9, 32'h0000_0099);
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 32'h0000_0099, 2'd2, 1'b0, 2'd0);
        tick();
        applyStimulus(1'b1, 5'd0, 32'h0000_BEEF, 1'b0, 5'd0, 32'h0, 2'd0, 1'b0, 2'd0);
        tick();
        idle();
        checkOutput("x0 alu slot rd_en", 32'(rd_en_o), 32'd1);
        checkOutput("x0 alu slot idx", 32'(rd_idx_o), 32'd9);
        drain("x0 drained");

        // Reset with two loads still queued
        expectWrite(5'd4, 32'h0000_00B0);
        expectWrite(5'd4, 32'h0000_00B1);
        applyStimulus(1'b1, 5'd4, 32'h0000_00B0, 1'b1, 5'd25, 32'h0000_0025, 2'd2, 1'b0, 2'd0);
        tick();
        applyStimulus(1'b1, 5'd4, 32'h0000_00B1, 1'b1, 5'd26, 32'h0000_0026, 2'd2, 1'b0, 2'd0);
        tick();
        idle();
        checkOutput("rst pend before", pend_o, 32'h0600_0000);
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        checkOutput("rst pend", pend_o, 32'd0);
        checkOutput("rst ready", 32'(lsu_ready_o), 32'd1);
        checkOutput("rst rd_en", 32'(rd_en_o), 32'd0);
        repeat (2) tick();
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            checkOutput("rst no write", 32'(rd_en_o), 32'd0);
        end
        checkOutput("rst scoreboard", sb.size(), 0);

        // Load accepted on the first edge after release
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd30, 32'h3030_3030, 2'd2, 1'b0, 2'd0);
        tick();
        @(negedge clk);
        rst_n = 1'b1;
        expectWrite(5'd30, 32'h3030_3030);
        tick();
        idle();
        checkOutput("post-rst pend x30", pend_o, 32'h4000_0000);
        drain("post-rst drained");

        repeat (2) tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
